uart_rx: RTL and testbench

Serial receiver for the UART peripheral at `uart_base_addr`. It is the receive counterpart of the existing transmit path. The block synchronises the asynchronous `rx` pin and decodes 8N1 frames at the baud rate set by `clks_per_bit`, sampling each bit once at mid-bit. Received bytes go into a small first-word-fall-through FIFO, which the bus side drains with a valid/ready handshake; framing and overrun errors are reported as one-cycle pulses.

---
 rtl/configure.sv | 8 +
 rtl/uart_rx_fifo.sv | 39 +++
 rtl/uart_rx.sv | 83 ++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/configure.sv
// configure: shared UART constants and receiver state encoding
package configure;
  localparam int clk_freq = 50_000_000;
  localparam int baudrate = 115_200;
  localparam int clks_per_bit = clk_freq / baudrate;
  localparam int uart_rx_fifo_depth = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO with occupancy-counted full/empty
module uart_rx_fifo #(
  parameter int fifo_depth = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  output logic       full,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty
);
  localparam int n = 1 << fifo_depth;
  logic [7:0] mem [n];
  logic [fifo_depth-1:0] wr_ptr, rd_ptr;
  logic [fifo_depth:0] count;
  logic do_push, do_pop;
  assign full = count == (fifo_depth + 1)'(n);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a push into a full FIFO only lands when a pop frees a slot in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < n; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (fifo_depth + 1)'(do_push) - (fifo_depth + 1)'(do_pop);
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, byte FIFO and error pulses
module uart_rx #(
  parameter int clks_per_bit = configure::clks_per_bit,
  parameter int fifo_depth = configure::uart_rx_fifo_depth
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       frame_err,
  output logic       overrun
);
  import configure::*;
  localparam int cnt_w = $clog2(clks_per_bit);
  localparam logic [cnt_w-1:0] half_cnt = cnt_w'(clks_per_bit / 2 - 1);
  localparam logic [cnt_w-1:0] bit_cnt = cnt_w'(clks_per_bit - 1);
  uart_rx_state_t state;
  logic rx_m, rx_s;
  logic [cnt_w-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic tick, push, pop, full, empty;
  assign tick = cnt == '0;
  assign push = state == STOP && tick && rx_s;
  assign pop = rvalid & rready;
  assign rvalid = ~empty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun <= push & full & ~pop;
      case (state)
        IDLE: if (!rx_s) begin
          cnt <= half_cnt;
          state <= START;
        end
        START: if (tick) begin
          cnt <= bit_cnt;
          idx <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt - 1'b1;
        DATA: if (tick) begin
          shift <= {rx_s, shift[7:1]};
          cnt <= bit_cnt;
          idx <= idx + 3'd1;
          state <= idx == 3'd7 ? STOP : DATA;
        end else cnt <= cnt - 1'b1;
        STOP: if (tick) begin
          frame_err <= ~rx_s;
          state <= rx_s ? IDLE : BREAK;
        end else cnt <= cnt - 1'b1;
        // a line held low after a bad stop bit must rise before a new start is accepted
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  uart_rx_fifo #(.fifo_depth(fifo_depth)) fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .wdata(shift),
    .full(full),
    .pop(pop),
    .rdata(rdata),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a byte scoreboard checked at every FIFO pop
module tb_uart_rx;
  import configure::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic rready = 1'b1;
  logic [7:0] rdata;
  logic rvalid, frame_err, overrun;
  logic [7:0] exp_q [$];
  logic [7:0] fb;
  logic rv_q = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, fall = 0, f = 0, rise_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  int vcnt = 0, pops = 0, fe_cnt = 0, ov_cnt = 0;
  int v0, p0, e0, o0;

  uart_rx #(.clks_per_bit(8), .fifo_depth(2)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .rdata(rdata),
    .rvalid(rvalid),
    .rready(rready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rvalid && !rv_q) rise_cyc = cyc;
    if (rvalid) vcnt++;
    rv_q = rvalid;
    if (rvalid && rready) begin
      n_cmp++;
      pops++;
      assert (exp_q.size() > 0 && rdata === exp_q[0])
      else begin
        n_bad++;
        $error("FAIL pop: got %h want %h (queued %0d)", rdata, exp_q.size() > 0 ? exp_q[0] : 8'h00, exp_q.size());
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic pop_at_stop);
    rx = 1'b0;
    fall = cyc;
    tick(8);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      tick(8);
    end
    rx = stop;
    if (pop_at_stop) begin
      tick(6);
      rready = 1'b1;
      tick(1);
      rready = 1'b0;
      tick(1);
    end else tick(8);
  endtask

  initial begin
    tick(3);
    chk("reset rvalid", 32'(rvalid), 0);
    chk("reset rdata", 32'(rdata), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick(4);
    v0 = vcnt; p0 = pops;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 1'b0);
    f = fall;
    tick(4);
    chk("single rvalid cycles", vcnt - v0, 1);
    chk("single latency", rise_cyc - f, 79);
    chk("single pops", pops - p0, 1);
    chk("single frame_err", fe_cnt, 0);
    chk("single overrun", ov_cnt, 0);
    v0 = vcnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(12);
    chk("glitch rvalid", vcnt - v0, 0);
    chk("glitch frame_err", fe_cnt, 0);
    chk("glitch idle", 32'(dut.state), 32'(IDLE));
    e0 = fe_cnt;
    send(8'hA3, 1'b0, 1'b0);
    f = fall;
    tick(20);
    rx = 1'b1;
    tick(8);
    p0 = pops;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0);
    tick(4);
    chk("framing pulses", fe_cnt - e0, 1);
    chk("framing timing", fe_cyc - f, 79);
    chk("framing pops", pops - p0, 1);
    rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 1'b0);
    end
    f = fall;
    tick(3);
    chk("overrun pulses", ov_cnt, 1);
    chk("overrun timing", ov_cyc - f, 79);
    chk("overrun head", 32'(rdata), 32'h01);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("drain rvalid", 32'(rvalid), 1);
    end
    @(negedge clock);
    chk("drain empty", 32'(rvalid), 0);
    chk("drain queue", exp_q.size(), 0);
    tick(1);
    rready = 1'b0;
    o0 = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i), 1'b1, 1'b0);
    end
    exp_q.push_back(8'h77);
    send(8'h77, 1'b1, 1'b1);
    tick(2);
    chk("full+pop overrun", ov_cnt - o0, 0);
    chk("full+pop rvalid", 32'(rvalid), 1);
    rready = 1'b1;
    tick(6);
    chk("full+pop queue", exp_q.size(), 0);
    chk("full+pop empty", 32'(rvalid), 0);
    rready = 1'b0;
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0);
    tick(2);
    chk("pre-reset rvalid", 32'(rvalid), 1);
    fb = 8'hF0;
    rx = 1'b0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      rx = fb[k];
      tick(8);
    end
    rx = fb[4];
    tick(4);
    reset = 1'b1;
    #1;
    chk("mid reset rvalid", 32'(rvalid), 0);
    chk("mid reset rdata", 32'(rdata), 0);
    chk("mid reset frame_err", 32'(frame_err), 0);
    chk("mid reset overrun", 32'(overrun), 0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_q.delete();
    rready = 1'b1;
    tick(4);
    p0 = pops;
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0);
    tick(4);
    chk("post reset pops", pops - p0, 1);
    chk("final queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
